ahb_bus_arbiter: RTL and testbench
==================================

AHB_BUS_ARBITER -- requirements
Module: ahb_bus_arbiter

Shares one AHB-style master port between the instruction-fetch requester (code, c_*) and the load/store requester (data, d_*).

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, the number of consecutive data grants allowed while code is waiting.
REQ-002 Port: HCLK  in  1  single clock; all state updates on the rising edge.
REQ-003 Port: HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-004 Ports: c_req in 1; c_addr in 32. Code read request; always a word read.
REQ-005 Ports: c_gnt out 1; c_done out 1; c_rdata out 32; c_err out 1. Code grant, completion, read data and error.
REQ-006 Ports: d_req in 1; d_addr in 32; d_write in 1; d_size in 3; d_wdata in 32. Data request (d_write 1 = store).
REQ-007 Ports: d_gnt out 1; d_done out 1; d_rdata out 32; d_err out 1. Data grant, completion, read data and error.
REQ-008 AHB outputs:
- HADDR out 32
- HTRANS out 2
- HWRITE out 1
- HSIZE out 3
- HBUST out 3
- HWDATA out 32
REQ-009 AHB inputs:
- HRDATA in 32
- HREADY in 1
- HRESP in 2

Function
REQ-010 State machine: IDLE, ADDR, DATA.
- IDLE -> ADDR on acceptance of a request.
- ADDR -> DATA on HREADY=1.
- DATA -> IDLE on HREADY=1.
REQ-011 Arbitration runs only in IDLE: the selected requester's x_gnt is asserted combinationally for that cycle.
- On the same edge the arbiter latches the owner and the request fields (code: write=0, size=3'b010).
REQ-012 Requesters hold x_req and their fields stable until they see x_gnt; the arbiter ignores x_req in ADDR and DATA.
REQ-013 Priority: data wins when both requesters are active, except when starve_cnt == STARVE_LIMIT, in which case code wins.
REQ-014 starve_cnt handling:
- Increments on each data grant while c_req=1, saturating at STARVE_LIMIT.
- Clears on a code grant, or in any cycle with c_req=0.
REQ-015 In ADDR: HTRANS=2'b10 (NONSEQ); HADDR, HWRITE and HSIZE come from the latched fields.
REQ-016 In IDLE and DATA: HTRANS=2'b00; HADDR, HWRITE and HSIZE hold their last value.
REQ-017 HBUST is constant 3'b000.
REQ-018 HWDATA drives the latched wdata during DATA and holds its last value otherwise.
REQ-019 Completion, in DATA with HREADY=1:
- The owner's x_done pulses for 1 cycle.
- x_rdata = HRDATA in that cycle.
- x_err = (HRESP==2'b01).
- The non-owner's done, err and gnt stay 0.
REQ-020 Wait states: with HREADY=0 in ADDR or DATA, the state and all AHB outputs hold.
- Unbounded waits are legal; no timeout.
REQ-021 Two-cycle ERROR response (HRESP=01, HREADY=0, then HREADY=1) completes with err=1 on the second cycle only.
REQ-022 Minimum transfer is 3 cycles (accept, ADDR, DATA); zero-wait back-to-back transfers issue every 3 cycles.
REQ-023 A request arriving during ADDR or DATA is evaluated in the next IDLE cycle.
REQ-024 Simultaneous requests with starve_cnt < STARVE_LIMIT: only d_gnt is asserted.

Reset
REQ-025 HRESETn=0 immediately forces the following, including mid-transfer (the transfer is abandoned with no done pulse):
- state=IDLE
- starve_cnt=0
- HTRANS=2'b00
- HADDR, HWDATA, latched fields = 0
- HWRITE=0
- HSIZE=3'b010
- all gnt, done and err outputs = 0
REQ-026 x_rdata is a combinational pass-through of HRDATA, is valid only while x_done=1, and has no reset value.
REQ-027 After HRESETn deasserts, the first grant can occur in the first IDLE cycle.

Structure
REQ-028 Shared package riscv_bus_pkg holds:
- HTRANS constants (IDLE, NONSEQ)
- HSIZE constants (BYTE, HALF, WORD)
- HRESP constants (OKAY, ERROR)
- the arbiter state encoding
REQ-029 One sub-module arb_priority holds the priority select and starve_cnt.
- Inputs: c_req, d_req, enable.
- Outputs: sel_code, sel_data.

Verification
REQ-030 Single code read: c_req=1, c_addr=0x100, HRDATA=0xDEADBEEF, HREADY=1 -> c_gnt in cycle 0, HTRANS=10 and HADDR=0x100 in cycle 1, c_done=1 and c_rdata=0xDEADBEEF in cycle 2.
REQ-031 Contention: c_req and d_req held high, STARVE_LIMIT=4 -> grant sequence D,D,D,D,C,D,D,D,D,C.
REQ-032 Data store with waits: d_write=1, d_size=000, d_addr=0x203, d_wdata=0x55, HREADY low 2 cycles in DATA -> HWDATA=0x55 held; d_done arrives 2 cycles late.
REQ-033 Error: two-cycle HRESP=01 on a data load -> d_err=1 coincident with d_done, and the next request is accepted normally.
REQ-034 Reset mid-transfer: HRESETn=0 during DATA -> outputs at reset values with no clock edge, and no x_done pulse.

Source files
------------

// File: rtl/riscv_bus_pkg.sv
// Shared AHB-lite bus constants and arbiter state encoding used by the
// instruction/data bus arbiter and its environment.
package riscv_bus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_ADDR = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } bus_req_t;

  function automatic logic is_error(input logic [1:0] resp);
    return (resp == HRESP_ERROR);
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Requester-side and AHB-side signals of the code/data bus arbiter.
// The arbiter uses the master view; the requesters and the slave use the other.
interface ahb_bus_arbiter_if;

  logic        c_req;
  logic [31:0] c_addr;
  logic        c_gnt;
  logic        c_done;
  logic [31:0] c_rdata;
  logic        c_err;

  logic        d_req;
  logic [31:0] d_addr;
  logic        d_write;
  logic [2:0]  d_size;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBUST;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic [1:0]  HRESP;

  modport master (
    input  c_req, c_addr, d_req, d_addr, d_write, d_size, d_wdata,
    input  HRDATA, HREADY, HRESP,
    output c_gnt, c_done, c_rdata, c_err, d_gnt, d_done, d_rdata, d_err,
    output HADDR, HTRANS, HWRITE, HSIZE, HBUST, HWDATA
  );

  modport slave (
    output c_req, c_addr, d_req, d_addr, d_write, d_size, d_wdata,
    output HRDATA, HREADY, HRESP,
    input  c_gnt, c_done, c_rdata, c_err, d_gnt, d_done, d_rdata, d_err,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBUST, HWDATA
  );

endinterface

// File: rtl/arb_priority.sv
// Code/data priority select: data wins by default, code wins once data has
// taken STARVE_LIMIT consecutive grants while code was waiting.
module arb_priority #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic c_req,
  input  logic d_req,
  input  logic enable,
  output logic sel_code,
  output logic sel_data
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_cnt_r;
  logic          at_limit_s;

  assign at_limit_s = (starve_cnt_r == LIMIT);

  // Priority select, only meaningful while the bus is free.
  always_comb begin
    sel_code = 1'b0;
    sel_data = 1'b0;
    if (enable && d_req && !(c_req && at_limit_s)) begin
      sel_data = 1'b1;
    end else if (enable && c_req) begin
      sel_code = 1'b1;
    end else begin
      sel_code = 1'b0;
      sel_data = 1'b0;
    end
  end

  // Starvation counter: saturating count of data grants made while code waits.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      starve_cnt_r <= '0;
    end else if (!c_req || sel_code) begin
      starve_cnt_r <= '0;
    end else if (sel_data && !at_limit_s) begin
      starve_cnt_r <= starve_cnt_r + CW'(1);
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Shares one AHB master port between the instruction-fetch (code) and
// load/store (data) requesters, one single transfer at a time.
module ahb_bus_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  ahb_bus_arbiter_if.master  bus
);

  logic [1:0]  state_r;
  logic        owner_code_r;
  bus_req_t    req_r;
  logic [31:0] hwdata_r;
  logic [1:0]  htrans_r;

  logic idle_s;
  logic sel_code_s;
  logic sel_data_s;
  logic finish_s;
  logic c_done_s;
  logic d_done_s;

  assign idle_s   = (state_r == ST_IDLE);
  assign finish_s = (state_r == ST_DATA) && bus.HREADY;

  arb_priority #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_prio (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .c_req    (bus.c_req),
    .d_req    (bus.d_req),
    .enable   (idle_s),
    .sel_code (sel_code_s),
    .sel_data (sel_data_s)
  );

  // Transfer sequencer: latch the winner's fields, run address then data phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r      <= ST_IDLE;
      owner_code_r <= 1'b0;
      req_r        <= '{addr: 32'h0, write: 1'b0, size: HSIZE_WORD, wdata: 32'h0};
      hwdata_r     <= 32'h0;
      htrans_r     <= HTRANS_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_code_s) begin
            state_r      <= ST_ADDR;
            owner_code_r <= 1'b1;
            req_r.addr   <= bus.c_addr;
            req_r.write  <= 1'b0;
            req_r.size   <= HSIZE_WORD;
            htrans_r     <= HTRANS_NONSEQ;
          end else if (sel_data_s) begin
            state_r      <= ST_ADDR;
            owner_code_r <= 1'b0;
            req_r        <= '{addr: bus.d_addr, write: bus.d_write,
                              size: bus.d_size, wdata: bus.d_wdata};
            htrans_r     <= HTRANS_NONSEQ;
          end
        end
        ST_ADDR: begin
          if (bus.HREADY) begin
            state_r  <= ST_DATA;
            htrans_r <= HTRANS_IDLE;
            hwdata_r <= req_r.wdata;
          end
        end
        ST_DATA: begin
          if (bus.HREADY) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          htrans_r <= HTRANS_IDLE;
        end
      endcase
    end
  end

  // Grants are combinational, so they are masked while reset is asserted.
  assign bus.c_gnt   = sel_code_s & HRESETn;
  assign bus.d_gnt   = sel_data_s & HRESETn;
  assign c_done_s    = finish_s & owner_code_r;
  assign d_done_s    = finish_s & ~owner_code_r;
  assign bus.c_done  = c_done_s;
  assign bus.d_done  = d_done_s;
  assign bus.c_err   = c_done_s & is_error(bus.HRESP);
  assign bus.d_err   = d_done_s & is_error(bus.HRESP);
  assign bus.c_rdata = bus.HRDATA;
  assign bus.d_rdata = bus.HRDATA;

  assign bus.HADDR  = req_r.addr;
  assign bus.HWRITE = req_r.write;
  assign bus.HSIZE  = req_r.size;
  assign bus.HTRANS = htrans_r;
  assign bus.HBUST  = 3'b000;
  assign bus.HWDATA = hwdata_r;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Self-checking bench for ahb_bus_arbiter: directed vector table, hand-written
// corner sequences, and random traffic against a transaction-level model.
module tb_ahb_bus_arbiter;
  import riscv_bus_pkg::*;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  ahb_bus_arbiter_if bus();

  ahb_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        c_req;
    logic        d_req;
    logic [31:0] addr;
    logic        d_write;
    logic [2:0]  d_size;
    logic [31:0] d_wdata;
    logic        hready;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic [1:0]  gnt;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  done;
    logic [1:0]  err;
    logic        chk_wd;
    logic [31:0] hwdata;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.c_req   = v.c_req;
    bus.c_addr  = v.addr;
    bus.d_req   = v.d_req;
    bus.d_addr  = v.addr;
    bus.d_write = v.d_write;
    bus.d_size  = v.d_size;
    bus.d_wdata = v.d_wdata;
    bus.HREADY  = v.hready;
    bus.HRESP   = v.hresp;
    bus.HRDATA  = v.hrdata;
  endtask

  task automatic clear_inputs();
    bus.c_req = 1'b0; bus.c_addr = 32'h0; bus.d_req = 1'b0; bus.d_addr = 32'h0;
    bus.d_write = 1'b0; bus.d_size = HSIZE_WORD; bus.d_wdata = 32'h0;
    bus.HREADY = 1'b1; bus.HRESP = HRESP_OKAY; bus.HRDATA = 32'h0;
  endtask

  // Random-phase reference model (transaction level)
  int          m_rem;
  int          m_streak;
  logic        m_own_code;
  logic [31:0] m_addr;
  logic        m_write;
  logic [2:0]  m_size;
  logic [31:0] m_wdata;
  logic        cp, dp;
  logic        got [10];
  int          exp_seq [10];
  int          ng;
  int          w;

  initial begin
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    // Reset state, with both requests raised to show grants are masked
    clear_inputs();
    rst_n = 1'b0;
    bus.c_req = 1'b1;
    bus.d_req = 1'b1;
    #12;
    chk("rst c_gnt",  32'(bus.c_gnt),  32'h0);
    chk("rst d_gnt",  32'(bus.d_gnt),  32'h0);
    chk("rst htrans", 32'(bus.HTRANS), 32'(HTRANS_IDLE));
    chk("rst haddr",  bus.HADDR,       32'h0);
    chk("rst hwrite", 32'(bus.HWRITE), 32'h0);
    chk("rst hsize",  32'(bus.HSIZE),  32'(HSIZE_WORD));
    chk("rst hwdata", bus.HWDATA,      32'h0);
    chk("rst hbust",  32'(bus.HBUST),  32'h0);
    chk("rst done",   32'({bus.c_done, bus.d_done, bus.c_err, bus.d_err}), 32'h0);
    bus.c_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Code read, data store with DATA waits, data load with ERROR, code read
    tbl[0]  = '{1'b1, 1'b0, 32'h100, 1'b0, HSIZE_WORD, 32'h0,  1'b1, HRESP_OKAY,  32'h0,
                2'b10, 2'b00, 32'h0,   1'b0, HSIZE_WORD, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, HSIZE_WORD, 32'h0,  1'b1, HRESP_OKAY,  32'h0,
                2'b00, 2'b10, 32'h100, 1'b0, HSIZE_WORD, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b0, HSIZE_WORD, 32'h0,  1'b1, HRESP_OKAY,  32'hDEADBEEF,
                2'b00, 2'b00, 32'h100, 1'b0, HSIZE_WORD, 2'b10, 2'b00, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 32'h203, 1'b1, HSIZE_BYTE, 32'h55, 1'b1, HRESP_OKAY,  32'h0,
                2'b01, 2'b00, 32'h100, 1'b0, HSIZE_WORD, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 1'b0, 32'h203, 1'b1, HSIZE_BYTE, 32'h55, 1'b1, HRESP_OKAY,  32'h0,
                2'b00, 2'b10, 32'h203, 1'b1, HSIZE_BYTE, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b0, 32'h203, 1'b1, HSIZE_BYTE, 32'h55, 1'b0, HRESP_OKAY,  32'h0,
                2'b00, 2'b00, 32'h203, 1'b1, HSIZE_BYTE, 2'b00, 2'b00, 1'b1, 32'h55};
    tbl[6]  = tbl[5];
    tbl[7]  = '{1'b0, 1'b0, 32'h203, 1'b1, HSIZE_BYTE, 32'h55, 1'b1, HRESP_OKAY,  32'h0,
                2'b00, 2'b00, 32'h203, 1'b1, HSIZE_BYTE, 2'b01, 2'b00, 1'b1, 32'h55};
    tbl[8]  = '{1'b0, 1'b1, 32'h300, 1'b0, HSIZE_WORD, 32'h0,  1'b1, HRESP_OKAY,  32'h0,
                2'b01, 2'b00, 32'h203, 1'b1, HSIZE_BYTE, 2'b00, 2'b00, 1'b1, 32'h55};
    tbl[9]  = '{1'b0, 1'b0, 32'h300, 1'b0, HSIZE_WORD, 32'h0,  1'b1, HRESP_OKAY,  32'h0,
                2'b00, 2'b10, 32'h300, 1'b0, HSIZE_WORD, 2'b00, 2'b00, 1'b1, 32'h55};
    tbl[10] = '{1'b0, 1'b0, 32'h300, 1'b0, HSIZE_WORD, 32'h0,  1'b0, HRESP_ERROR, 32'h0,
                2'b00, 2'b00, 32'h300, 1'b0, HSIZE_WORD, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 32'h300, 1'b0, HSIZE_WORD, 32'h0,  1'b1, HRESP_ERROR, 32'hCAFEF00D,
                2'b00, 2'b00, 32'h300, 1'b0, HSIZE_WORD, 2'b01, 2'b01, 1'b0, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 32'h104, 1'b0, HSIZE_WORD, 32'h0,  1'b1, HRESP_OKAY,  32'h0,
                2'b10, 2'b00, 32'h300, 1'b0, HSIZE_WORD, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[13] = '{1'b0, 1'b0, 32'h104, 1'b0, HSIZE_WORD, 32'h0,  1'b1, HRESP_OKAY,  32'h0,
                2'b00, 2'b10, 32'h104, 1'b0, HSIZE_WORD, 2'b00, 2'b00, 1'b0, 32'h0};
    tbl[14] = '{1'b0, 1'b0, 32'h104, 1'b0, HSIZE_WORD, 32'h0,  1'b1, HRESP_OKAY,  32'h12345678,
                2'b00, 2'b00, 32'h104, 1'b0, HSIZE_WORD, 2'b10, 2'b00, 1'b0, 32'h0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b0, HSIZE_WORD, 32'h0,  1'b1, HRESP_OKAY,  32'h0,
                2'b00, 2'b00, 32'h104, 1'b0, HSIZE_WORD, 2'b00, 2'b00, 1'b0, 32'h0};

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d gnt", i),    32'({bus.c_gnt, bus.d_gnt}),   32'(tbl[i].gnt));
      chk($sformatf("vec%0d htrans", i), 32'(bus.HTRANS),               32'(tbl[i].htrans));
      chk($sformatf("vec%0d haddr", i),  bus.HADDR,                     tbl[i].haddr);
      chk($sformatf("vec%0d hwrite", i), 32'(bus.HWRITE),               32'(tbl[i].hwrite));
      chk($sformatf("vec%0d hsize", i),  32'(bus.HSIZE),                32'(tbl[i].hsize));
      chk($sformatf("vec%0d done", i),   32'({bus.c_done, bus.d_done}), 32'(tbl[i].done));
      chk($sformatf("vec%0d err", i),    32'({bus.c_err, bus.d_err}),   32'(tbl[i].err));
      if (tbl[i].chk_wd) chk($sformatf("vec%0d hwdata", i), bus.HWDATA, tbl[i].hwdata);
      if (tbl[i].done[1]) chk($sformatf("vec%0d c_rdata", i), bus.c_rdata, tbl[i].hrdata);
      if (tbl[i].done[0]) chk($sformatf("vec%0d d_rdata", i), bus.d_rdata, tbl[i].hrdata);
    end

    // Contention: both requests held high, zero-wait slave
    ng = 0;
    for (int cyc = 0; cyc < 60 && ng < 10; cyc++) begin
      @(posedge clk); #1;
      bus.c_req = 1'b1; bus.d_req = 1'b1; bus.HREADY = 1'b1; bus.HRESP = HRESP_OKAY;
      @(negedge clk);
      chk("cont one-hot gnt", 32'(bus.c_gnt & bus.d_gnt), 32'h0);
      if (bus.c_gnt || bus.d_gnt) begin
        got[ng] = bus.c_gnt;
        ng++;
      end
    end
    chk("cont grant count", ng, 32'd10);
    for (int i = 0; i < 10; i++) chk($sformatf("cont grant%0d is_code", i), 32'(got[i]), exp_seq[i]);

    // Reset during the data phase of a store: no done, outputs forced at once
    @(posedge clk); #1;
    bus.c_req = 1'b0; bus.d_req = 1'b0;
    w = 0;
    do begin
      @(posedge clk); #1;
      bus.d_req = 1'b1; bus.d_addr = 32'h400; bus.d_write = 1'b1;
      bus.d_size = HSIZE_HALF; bus.d_wdata = 32'hA5A50001; bus.HREADY = 1'b1;
      @(negedge clk);
      w++;
    end while (!bus.d_gnt && w < 10);
    chk("rstmid accept", 32'(bus.d_gnt), 32'h1);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    bus.HREADY = 1'b1;
    #1;
    chk("rstmid in data", 32'(bus.d_done), 32'h1);
    rst_n = 1'b0;
    bus.c_req = 1'b1; bus.c_addr = 32'h500;
    #1;
    chk("rstmid d_done",  32'(bus.d_done), 32'h0);
    chk("rstmid c_gnt",   32'(bus.c_gnt),  32'h0);
    chk("rstmid htrans",  32'(bus.HTRANS), 32'(HTRANS_IDLE));
    chk("rstmid haddr",   bus.HADDR,       32'h0);
    chk("rstmid hwdata",  bus.HWDATA,      32'h0);
    chk("rstmid hwrite",  32'(bus.HWRITE), 32'h0);
    chk("rstmid hsize",   32'(bus.HSIZE),  32'(HSIZE_WORD));
    @(posedge clk); #1;
    chk("rstmid hold done", 32'({bus.c_done, bus.d_done}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-rst first grant", 32'(bus.c_gnt), 32'h1);
    @(posedge clk); #1;
    bus.c_req = 1'b0;
    @(negedge clk);
    chk("post-rst htrans", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
    chk("post-rst haddr",  bus.HADDR,       32'h500);
    @(posedge clk); #1;
    bus.HRDATA = 32'h0BADF00D;
    @(negedge clk);
    chk("post-rst c_done", 32'(bus.c_done), 32'h1);

    // Random traffic against the transaction-level model
    @(posedge clk); #1;
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    m_rem = 0; m_streak = 0; m_own_code = 1'b0;
    m_addr = 32'h0; m_write = 1'b0; m_size = HSIZE_WORD; m_wdata = 32'h0;
    cp = 1'b0; dp = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic pick_c, pick_d, fin;
      @(posedge clk); #1;
      if (!cp && $urandom_range(0, 99) < 40) begin
        cp = 1'b1; bus.c_addr = $urandom;
      end
      if (!dp && $urandom_range(0, 99) < 70) begin
        dp = 1'b1; bus.d_addr = $urandom; bus.d_write = 1'($urandom_range(0, 1));
        bus.d_size = 3'($urandom_range(0, 2)); bus.d_wdata = $urandom;
      end
      bus.c_req  = cp;
      bus.d_req  = dp;
      bus.HREADY = ($urandom_range(0, 99) < 70);
      bus.HRESP  = ($urandom_range(0, 3) == 0) ? HRESP_ERROR : HRESP_OKAY;
      bus.HRDATA = $urandom;
      @(negedge clk);
      pick_c = (m_rem == 0) && cp && (!dp || m_streak == LIMIT);
      pick_d = (m_rem == 0) && dp && !pick_c;
      fin    = (m_rem == 1) && bus.HREADY;
      chk("rnd c_gnt",  32'(bus.c_gnt),  32'(pick_c));
      chk("rnd d_gnt",  32'(bus.d_gnt),  32'(pick_d));
      chk("rnd htrans", 32'(bus.HTRANS), (m_rem == 2) ? 32'(HTRANS_NONSEQ) : 32'(HTRANS_IDLE));
      chk("rnd haddr",  bus.HADDR,       m_addr);
      chk("rnd hwrite", 32'(bus.HWRITE), 32'(m_write));
      chk("rnd hsize",  32'(bus.HSIZE),  32'(m_size));
      chk("rnd c_done", 32'(bus.c_done), 32'(fin && m_own_code));
      chk("rnd d_done", 32'(bus.d_done), 32'(fin && !m_own_code));
      chk("rnd c_err",  32'(bus.c_err),  32'(fin && m_own_code && bus.HRESP == HRESP_ERROR));
      chk("rnd d_err",  32'(bus.d_err),  32'(fin && !m_own_code && bus.HRESP == HRESP_ERROR));
      if (fin && m_own_code)  chk("rnd c_rdata", bus.c_rdata, bus.HRDATA);
      if (fin && !m_own_code) chk("rnd d_rdata", bus.d_rdata, bus.HRDATA);
      if (m_rem == 1 && !m_own_code) chk("rnd hwdata", bus.HWDATA, m_wdata);
      if (!cp || pick_c)  m_streak = 0;
      else if (pick_d)    m_streak = (m_streak < LIMIT) ? m_streak + 1 : LIMIT;
      if (pick_c) begin
        m_rem = 2; m_own_code = 1'b1; m_addr = bus.c_addr; m_write = 1'b0; m_size = HSIZE_WORD;
        cp = 1'b0;
      end else if (pick_d) begin
        m_rem = 2; m_own_code = 1'b0; m_addr = bus.d_addr; m_write = bus.d_write;
        m_size = bus.d_size; m_wdata = bus.d_wdata;
        dp = 1'b0;
      end else if (m_rem > 0 && bus.HREADY) begin
        m_rem = m_rem - 1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
